ram128_wb_bridge: RTL and testbench
===================================

Name: ram128_wb_bridge

Overview:
- Wishbone classic slave that maps a 128 x 32-bit RAM macro into the management SoC address space.
- It sits directly upstream of the RAM macro and drives its EN0, WE0, A0 and Di0 pins. It captures Do0 and returns the data with a registered acknowledge.
- The RAM always writes full words, so the bridge performs read-modify-write for partial byte-select writes.

Parameters:
- BASE_ADDR, 32'h3000_0000, base byte address of the RAM window.
- ADDR_MASK, 32'hFFFF_FE00, mask for address decode. Hit when (wbs_adr_i & ADDR_MASK) == BASE_ADDR, giving a 512-byte window.

Ports:
- CLK  input  1  clock shared with the RAM macro
- RST_N  input  1  asynchronous, active-low reset
- wbs_cyc_i  input  1  bus cycle
- wbs_stb_i  input  1  strobe
- wbs_we_i  input  1  1 = write
- wbs_sel_i  input  4  byte selects; bit n covers bits [8n+7:8n]
- wbs_adr_i  input  32  byte address; word index is [8:2]
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  single-cycle acknowledge
- wbs_dat_o  output  32  read data
- ram_en  output  1  to RAM EN0
- ram_we  output  4  to RAM WE0
- ram_addr  output  7  to RAM A0
- ram_din  output  32  to RAM Di0
- ram_dout  input  32  from RAM Do0

Behaviour:
- Reset (RST_N low, async): state IDLE. wbs_ack_o, wbs_dat_o, ram_en, ram_we, ram_addr and ram_din all 0.
- RAM timing contract, for a request presented at edge N:
  - A0 is sampled at edge N.
  - Do0 is valid after edge N+1 only if EN0 is also high at N+1.
  - A write with WE0 != 0 at edge N commits the whole word at edge N+1, whether or not EN0 is high at N+1.
- Request accept: only in IDLE, when cyc & stb & hit. Accept registers the word address, wbs_dat_i, wbs_sel_i and wbs_we_i. Non-hit requests are ignored, with no ack.
- FSM states: IDLE, RD_A, RD_D, RD_CAP, MERGE, WR_A, WR_C, ACK.
- Read (we=0):
  - IDLE -> RD_A: ram_en=1, ram_we=0, ram_addr valid.
  - -> RD_D: ram_en=1, same address.
  - -> RD_CAP: ram_dout valid.
  - Edge leaving RD_CAP loads wbs_dat_o = ram_dout -> ACK.
  - Accept at edge k gives ack high during the cycle after edge k+3.
- Full write (sel=4'hF):
  - IDLE -> WR_A: ram_en=1, ram_we=4'hF, ram_din = captured data.
  - -> WR_C: ram_en=0, ram_we=0; the commit occurs on the edge leaving WR_C.
  - -> ACK. Ack high during the cycle after edge k+2.
- Partial write (sel not 0 and not F):
  - Read phase RD_A, RD_D, RD_CAP.
  - On the edge leaving RD_CAP, register merged word: byte n = sel[n] ? wbs_dat byte n : ram_dout byte n.
  - Then MERGE (1 idle cycle, ram_en=0) -> WR_A -> WR_C -> ACK.
  - Ack high during the cycle after edge k+6.
- Write with sel=0: IDLE -> ACK directly, no RAM access. Ack high during the cycle after edge k.
- ACK state: wbs_ack_o=1 for exactly one cycle, then IDLE. A new request can be accepted on the first IDLE cycle.
- wbs_dat_o holds its last read value and is unchanged by writes.
- Read-after-write: a read accepted in the IDLE following a write ack returns the new data; the commit has already happened.
- cyc or stb dropped mid-transaction: the transaction completes, and ack is still pulsed; the master ignores it.
- Reset mid-transaction: the FSM aborts to IDLE and outputs clear. A RAM write already issued in WR_A may still commit; the macro has no reset. RAM contents are unaffected by reset otherwise.
- Only one outstanding transaction; no pipelining.

Test Plan:
- Full write then read: write 0xDEADBEEF, sel F, word 5 (addr BASE+0x14); then read word 5. Write ack 3 edges after accept; read ack 4 edges after accept; wbs_dat_o = 0xDEADBEEF.
- Partial write: word 9 = 0x11223344, then write 0xAABBCCDD with sel=4'b0101. Read returns 0x11BB33DD; write ack 7 edges after accept.
- Address decode: request at BASE+0x200 (miss) held 10 cycles -> no ack, ram_en stays 0. Word 127 (BASE+0x1FC) write/read round-trips 0x0000_007F; word 0 unaffected.
- sel=0 write to word 3 holding 0xCAFEF00D -> ack 1 edge after accept, ram_en never asserted, read still returns 0xCAFEF00D.
- Back-to-back: write word 2 = 0x1, write word 2 = 0x2, read word 2 with no idle gaps -> exactly one ack per request, read returns 0x2.
- Reset mid-read: assert RST_N low in RD_D -> wbs_ack_o, ram_en and wbs_dat_o go 0 immediately. After release, a read of a previously written word returns correct data.

Source files
------------

// File: rtl/ram128_wb_bridge.sv
// Wishbone classic slave bridging the management SoC bus to a 128 x 32-bit
// RAM macro. Partial byte-select writes are handled as read-modify-write,
// because the macro only ever commits full words.
module ram128_wb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FE00
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [6:0]  ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        RD_CAP,
        MERGE,
        WR_A,
        WR_C,
        ACK
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_ram_en;
    logic [3:0]  r_ram_we;
    logic [6:0]  r_ram_addr;
    logic [31:0] r_ram_din;

    logic        w_hit;
    logic        w_req;
    logic [6:0]  w_word;
    logic [31:0] w_merged;

    assign w_hit  = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    assign w_req  = wbs_cyc_i & wbs_stb_i & w_hit;
    assign w_word = wbs_adr_i[8:2];

    // Byte-wise merge of captured write data over the word just read back.
    always_comb begin
        // NOTE: a default before the loop keeps this purely combinational;
        // any bit left unassigned on some path would infer a latch.
        w_merged = ram_dout;
        for (int n = 0; n < 4; n++) begin
            if (r_sel[n]) begin
                w_merged[8*n +: 8] = r_wdata[8*n +: 8];
            end
        end
    end

    // Transaction FSM; every output to the bus and the macro is registered here.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_wdata    <= 32'h0;
            r_ack      <= 1'b0;
            r_dat      <= 32'h0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 4'h0;
            r_ram_addr <= 7'h0;
            r_ram_din  <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge value of every other register.
            case (r_state)
                IDLE: begin
                    r_ack    <= 1'b0;
                    r_ram_en <= 1'b0;
                    r_ram_we <= 4'h0;
                    if (w_req) begin
                        r_we       <= wbs_we_i;
                        r_sel      <= wbs_sel_i;
                        r_wdata    <= wbs_dat_i;
                        r_ram_addr <= w_word;
                        if (wbs_we_i && wbs_sel_i == 4'h0) begin
                            // Nothing to write: acknowledge without touching the RAM.
                            r_ack   <= 1'b1;
                            r_state <= ACK;
                        end else if (wbs_we_i && wbs_sel_i == 4'hF) begin
                            r_ram_en  <= 1'b1;
                            r_ram_we  <= 4'hF;
                            r_ram_din <= wbs_dat_i;
                            r_state   <= WR_A;
                        end else begin
                            // Plain reads and the read half of read-modify-write.
                            r_ram_en <= 1'b1;
                            r_state  <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    r_state <= RD_D;
                end
                RD_D: begin
                    // Enable was high on this edge, so Do0 is valid afterwards.
                    r_ram_en <= 1'b0;
                    r_state  <= RD_CAP;
                end
                RD_CAP: begin
                    if (r_we) begin
                        r_ram_din <= w_merged;
                        r_state   <= MERGE;
                    end else begin
                        r_dat   <= ram_dout;
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                MERGE: begin
                    r_ram_en <= 1'b1;
                    r_ram_we <= 4'hF;
                    r_state  <= WR_A;
                end
                WR_A: begin
                    // Macro latched the write on this edge; it commits on the next.
                    r_ram_en <= 1'b0;
                    r_ram_we <= 4'h0;
                    r_state  <= WR_C;
                end
                WR_C: begin
                    r_ack   <= 1'b1;
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack    <= 1'b0;
                    r_ram_en <= 1'b0;
                    r_ram_we <= 4'h0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;

endmodule

// File: tb/tb_ram128_wb_bridge.sv
// Directed bench for ram128_wb_bridge with a behavioural model of the RAM
// macro's latency contract.
module tb_ram128_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [6:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'h0;

    int checks = 0;
    int failures = 0;
    int en_cnt = 0;
    int ack_cnt = 0;

    always #5 CLK = ~CLK;

    ram128_wb_bridge dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // RAM macro model: address sampled at edge N, read data after N+1 only if
    // EN is high at N+1, a write issued at N commits at N+1 regardless.
    logic [31:0] mem [128];
    logic        pr_v = 1'b0;
    logic [6:0]  pr_a = 7'h0;
    logic        pw_v = 1'b0;
    logic [6:0]  pw_a = 7'h0;
    logic [3:0]  pw_we = 4'h0;
    logic [31:0] pw_d = 32'h0;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    initial for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    always @(posedge CLK) begin
        if (pw_v) mem[pw_a] <= byte_merge(mem[pw_a], pw_d, pw_we);
        if (pr_v && ram_en) ram_dout <= mem[pr_a];
        pw_v  <= ram_en && (ram_we != 4'h0);
        pw_a  <= ram_addr;
        pw_we <= ram_we;
        pw_d  <= ram_din;
        pr_v  <= ram_en && (ram_we == 4'h0);
        pr_a  <= ram_addr;
    end

    always @(negedge CLK) begin
        if (ram_en) en_cnt++;
        if (wbs_ack_o) ack_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus transaction; edges counts clock edges from driving the request
    // until ack is seen. With keep=1 the strobe stays up for a following call.
    task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, input bit keep, output int edges);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        edges = 0;
        do begin
            @(posedge CLK);
            #1;
            edges++;
        end while (!wbs_ack_o && edges < 20);
        if (!keep) begin
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
            @(posedge CLK);
            #1;
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          lat;
        logic [31:0] rdat;
        bit          no_en;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int          lat, l1, l2, l3, en0, ack0;
        logic [31:0] last_rd;

        vecs[0]  = '{1'b1, 4'hF, BASE + 32'h014, 32'hDEAD_BEEF, 3, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 4'hF, BASE + 32'h014, 32'h0,         4, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'hF, BASE + 32'h024, 32'h1122_3344, 3, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 4'h5, BASE + 32'h024, 32'hAABB_CCDD, 7, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 4'hF, BASE + 32'h024, 32'h0,         4, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b1, 4'hA, BASE + 32'h024, 32'h9988_7766, 7, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 4'hF, BASE + 32'h024, 32'h0,         4, 32'h99BB_77DD, 1'b0};
        vecs[7]  = '{1'b1, 4'hF, BASE + 32'h000, 32'h1234_5678, 3, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 4'hF, BASE + 32'h1FC, 32'h0000_007F, 3, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 4'hF, BASE + 32'h1FC, 32'h0,         4, 32'h0000_007F, 1'b0};
        vecs[10] = '{1'b0, 4'hF, BASE + 32'h000, 32'h0,         4, 32'h1234_5678, 1'b0};
        vecs[11] = '{1'b1, 4'hF, BASE + 32'h00C, 32'hCAFE_F00D, 3, 32'h0, 1'b0};
        vecs[12] = '{1'b1, 4'h0, BASE + 32'h00C, 32'hFFFF_FFFF, 1, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 4'hF, BASE + 32'h00C, 32'h0,         4, 32'hCAFE_F00D, 1'b0};

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ack",  {31'h0, wbs_ack_o}, 32'h0);
        check("rst_dat",  wbs_dat_o, 32'h0);
        check("rst_en",   {31'h0, ram_en}, 32'h0);
        check("rst_we",   {28'h0, ram_we}, 32'h0);
        check("rst_addr", {25'h0, ram_addr}, 32'h0);
        check("rst_din",  ram_din, 32'h0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        last_rd = 32'h0;
        for (int i = 0; i < 14; i++) begin
            en0 = en_cnt;
            xfer(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, 1'b0, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            if (!vecs[i].we) begin
                check($sformatf("vec%0d_rdata", i), wbs_dat_o, vecs[i].rdat);
                last_rd = vecs[i].rdat;
            end else begin
                check($sformatf("vec%0d_dat_hold", i), wbs_dat_o, last_rd);
            end
            if (vecs[i].no_en)
                check($sformatf("vec%0d_no_ram_en", i), en_cnt - en0, 32'h0);
        end

        // Out-of-window request held for 10 cycles.
        en0  = en_cnt;
        ack0 = ack_cnt;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = BASE + 32'h200;
        repeat (10) @(posedge CLK);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        check("miss_no_ack", ack_cnt - ack0, 32'h0);
        check("miss_no_en",  en_cnt - en0, 32'h0);
        @(posedge CLK);
        #1;

        // Back-to-back with strobe held: each following request costs one
        // extra edge for the ACK->IDLE transition.
        ack0 = ack_cnt;
        xfer(1'b1, 4'hF, BASE + 32'h008, 32'h1, 1'b1, l1);
        xfer(1'b1, 4'hF, BASE + 32'h008, 32'h2, 1'b1, l2);
        xfer(1'b0, 4'hF, BASE + 32'h008, 32'h0, 1'b0, l3);
        check("b2b_lat1", l1, 3);
        check("b2b_lat2", l2, 4);
        check("b2b_lat3", l3, 5);
        check("b2b_acks", ack_cnt - ack0, 32'd3);
        check("b2b_rdata", wbs_dat_o, 32'h2);

        // Reset asserted while the FSM sits in RD_D.
        xfer(1'b1, 4'hF, BASE + 32'h01C, 32'h0BAD_C0DE, 1'b0, lat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = BASE + 32'h01C;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst_ack", {31'h0, wbs_ack_o}, 32'h0);
        check("midrst_en",  {31'h0, ram_en}, 32'h0);
        check("midrst_dat", wbs_dat_o, 32'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        xfer(1'b0, 4'hF, BASE + 32'h01C, 32'h0, 1'b0, lat);
        check("postrst_lat",   lat, 4);
        check("postrst_rdata", wbs_dat_o, 32'h0BAD_C0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
